// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin pick helper for FIFO write-port arbiters.
// The pick scans ptr+1, ptr+2, ... modulo n and returns the first valid index.
package fifo_arb_pkg;

   typedef enum logic {IDLE, LOCK} arb_state_t;

   localparam int RR_MAX = 32;

   typedef struct packed {
      logic        found;
      logic [31:0] idx;
   } pick_t;

   // n is an elaboration constant, so the modulo folds away in synthesis
   function automatic pick_t rr_pick(
      input logic [RR_MAX-1:0] valid,
      input int                ptr,
      input int                n
   );
      pick_t      p;
      logic [4:0] idx;
      p   = '0;
      idx = '0;
      for (int k = 1; k <= RR_MAX; k++) begin
         if (k <= n && !p.found) begin
            idx = 5'((ptr + k) % n);
            if (valid[idx]) begin
               p.found = 1'b1;
               p.idx   = 32'(idx);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin select: first valid index after i_ptr.
// N may be any value from 2 up to RR_MAX, power of two or not.
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_ptr,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   pick_t w_pick;

   assign w_pick  = rr_pick(RR_MAX'(i_valid), int'(i_ptr), N);
   assign o_found = w_pick.found;
   assign o_idx   = IW'(w_pick.idx);

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port.
// Beats pass combinationally to the FIFO in the cycle they are accepted.
module fifo_wr_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_BURST  = 8,
   localparam int IW         = $clog2(NUM_REQ),
   localparam int CW         = $clog2(MAX_BURST + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          full_i,
   output logic                          wren_o,
   output logic [DATA_WIDTH-1:0]         wdata_o,
   output logic [IW-1:0]                 grant_id_o,
   output logic                          busy_o
);

   arb_state_t          r_state, w_state_nxt;
   logic [IW-1:0]       r_grant, w_grant_nxt;
   logic [IW-1:0]       r_ptr, w_ptr_nxt;
   logic [CW-1:0]       r_cnt, w_cnt_nxt;
   logic [CW-1:0]       w_cnt_inc;
   logic [IW-1:0]       w_pick_idx;
   logic                w_pick_found;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                w_sel_valid;
   logic                w_sel_last;

   rr_priority_picker #(.N(NUM_REQ)) u_pick (
      .i_valid (req_valid_i),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   assign w_cnt_inc  = r_cnt + CW'(1);
   assign grant_id_o = r_grant;
   assign busy_o     = (r_state == LOCK);

   always_comb begin
      w_sel_data  = '0;
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant == IW'(i)) begin
            w_sel_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_valid = req_valid_i[i];
            w_sel_last  = req_last_i[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      req_ready_o = '0;
      wren_o      = 1'b0;
      wdata_o     = '0;
      unique case (r_state)
         IDLE: begin
            if (w_pick_found) begin
               w_grant_nxt = w_pick_idx;
               w_cnt_nxt   = '0;
               w_state_nxt = LOCK;
            end
         end
         LOCK: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready_o[i] = (r_grant == IW'(i)) & ~full_i;
            end
            wren_o  = w_sel_valid & ~full_i;
            wdata_o = w_sel_data;
            if (wren_o) begin
               w_cnt_nxt = w_cnt_inc;
               // release on packet end or when the burst budget is spent
               if (w_sel_last || w_cnt_inc == CW'(MAX_BURST)) begin
                  w_ptr_nxt   = r_grant;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= IW'(NUM_REQ - 1);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Directed bench for fifo_wr_rr_arbiter (4 requesters, 32-bit, burst 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_fifo_wr_rr_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   vld;
   logic [3:0]   lst;
   logic [127:0] dat;
   logic [3:0]   rdy;
   logic         full;
   logic         wren;
   logic [31:0]  wdata;
   logic [1:0]   gid;
   logic         busy;

   int n_chk;
   int n_err;

   fifo_wr_rr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (32),
      .MAX_BURST  (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (vld),
      .req_last_i  (lst),
      .req_data_i  (dat),
      .req_ready_o (rdy),
      .full_i      (full),
      .wren_o      (wren),
      .wdata_o     (wdata),
      .grant_id_o  (gid),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic setd(input int i, input logic [31:0] v);
      dat[i*32 +: 32] = v;
   endtask

   task automatic chk(
      input string       tag,
      input logic        ew,
      input logic [1:0]  eg,
      input logic [31:0] ed,
      input logic [3:0]  er,
      input logic        eb
   );
      n_chk++;
      assert (wren === ew) else begin
         n_err++;
         $error("FAIL %s wren got %b exp %b", tag, wren, ew);
      end
      n_chk++;
      assert (gid === eg) else begin
         n_err++;
         $error("FAIL %s grant got %0d exp %0d", tag, gid, eg);
      end
      n_chk++;
      assert (wdata === ed) else begin
         n_err++;
         $error("FAIL %s wdata got %h exp %h", tag, wdata, ed);
      end
      n_chk++;
      assert (rdy === er) else begin
         n_err++;
         $error("FAIL %s ready got %b exp %b", tag, rdy, er);
      end
      n_chk++;
      assert (busy === eb) else begin
         n_err++;
         $error("FAIL %s busy got %b exp %b", tag, busy, eb);
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      vld   = '0;
      lst   = '0;
      dat   = '0;
      full  = 1'b0;
      cyc();
      cyc();
      #1 chk("reset", 0, 0, 0, 4'b0000, 0);
      rst_n = 1'b1;

      // 1: single-beat packets from all four, grants 0,1,2,3
      vld = 4'hf;
      lst = 4'hf;
      for (int i = 0; i < 4; i++) setd(i, 32'hA0 + 32'(i));
      for (int i = 0; i < 4; i++) begin
         #1 chk("s1_idle", 0, (i == 0) ? 2'd0 : 2'(i - 1), 0, 4'b0000, 0);
         cyc();
         #1 chk("s1_lock", 1, 2'(i), 32'hA0 + 32'(i), 4'(1 << i), 1);
         cyc();
      end
      vld = '0;
      lst = '0;

      // 2: req1 3-beat packet holds port against req2 (ptr=3)
      vld = 4'b0110;
      lst = 4'b0100;
      setd(1, 32'hB0);
      setd(2, 32'hC0);
      #1 chk("s2_idle", 0, 3, 0, 4'b0000, 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
         setd(1, 32'hB0 + 32'(k));
         lst[1] = (k == 2);
         #1 chk("s2_req1", 1, 1, 32'hB0 + 32'(k), 4'b0010, 1);
         cyc();
      end
      vld[1] = 1'b0;
      lst[1] = 1'b0;
      #1 chk("s2_idle2", 0, 1, 0, 4'b0000, 0);
      cyc();
      #1 chk("s2_req2", 1, 2, 32'hC0, 4'b0100, 1);
      cyc();
      vld = '0;
      lst = '0;

      // 3: 12-beat packet from req0 cut at 8, req3 slips in
      vld = 4'b0001;
      setd(0, 32'h100);
      #1 chk("s3_idle", 0, 2, 0, 4'b0000, 0);
      cyc();
      vld[3] = 1'b1;
      lst[3] = 1'b1;
      setd(3, 32'h300);
      for (int k = 0; k < 8; k++) begin
         setd(0, 32'h100 + 32'(k));
         #1 chk("s3_burst", 1, 0, 32'h100 + 32'(k), 4'b0001, 1);
         cyc();
      end
      setd(0, 32'h108);
      #1 chk("s3_cut", 0, 0, 0, 4'b0000, 0);
      cyc();
      #1 chk("s3_req3", 1, 3, 32'h300, 4'b1000, 1);
      cyc();
      vld[3] = 1'b0;
      lst[3] = 1'b0;
      #1 chk("s3_idle3", 0, 3, 0, 4'b0000, 0);
      cyc();
      for (int k = 8; k < 12; k++) begin
         setd(0, 32'h100 + 32'(k));
         lst[0] = (k == 11);
         #1 chk("s3_rest", 1, 0, 32'h100 + 32'(k), 4'b0001, 1);
         cyc();
      end
      vld = '0;
      lst = '0;

      // 4: full held 5 cycles mid-packet (ptr=0 -> req1)
      vld = 4'b0010;
      setd(1, 32'hD0);
      #1 chk("s4_idle", 0, 0, 0, 4'b0000, 0);
      cyc();
      #1 chk("s4_b0", 1, 1, 32'hD0, 4'b0010, 1);
      cyc();
      setd(1, 32'hD1);
      full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk("s4_full", 0, 1, 32'hD1, 4'b0000, 1);
         cyc();
      end
      full = 1'b0;
      #1 chk("s4_b1", 1, 1, 32'hD1, 4'b0010, 1);
      cyc();
      setd(1, 32'hD2);
      lst[1] = 1'b1;
      #1 chk("s4_b2", 1, 1, 32'hD2, 4'b0010, 1);
      cyc();
      vld = '0;
      lst = '0;

      // 5: req2 drops valid 3 cycles while req0/req3 wait (ptr=1)
      vld = 4'b1101;
      lst = 4'b1001;
      setd(0, 32'hE00);
      setd(2, 32'hE0);
      setd(3, 32'hE30);
      #1 chk("s5_idle", 0, 1, 0, 4'b0000, 0);
      cyc();
      #1 chk("s5_b0", 1, 2, 32'hE0, 4'b0100, 1);
      cyc();
      vld[2] = 1'b0;
      setd(2, 32'hE1);
      for (int k = 0; k < 3; k++) begin
         #1 chk("s5_hold", 0, 2, 32'hE1, 4'b0100, 1);
         cyc();
      end
      vld[2] = 1'b1;
      lst[2] = 1'b1;
      #1 chk("s5_b1", 1, 2, 32'hE1, 4'b0100, 1);
      cyc();
      vld[2] = 1'b0;
      lst[2] = 1'b0;
      #1 chk("s5_idle2", 0, 2, 0, 4'b0000, 0);
      cyc();
      #1 chk("s5_req3", 1, 3, 32'hE30, 4'b1000, 1);
      cyc();
      vld = '0;
      lst = '0;

      // 6: async reset during beat 2 of req3 packet
      vld = 4'b1000;
      setd(3, 32'hF0);
      #1 chk("s6_idle", 0, 3, 0, 4'b0000, 0);
      cyc();
      #1 chk("s6_b0", 1, 3, 32'hF0, 4'b1000, 1);
      cyc();
      setd(3, 32'hF1);
      #1 chk("s6_b1", 1, 3, 32'hF1, 4'b1000, 1);
      #1 rst_n = 1'b0;
      #1 chk("s6_rst", 0, 0, 0, 4'b0000, 0);
      cyc();
      rst_n = 1'b1;
      vld = 4'b1001;
      lst = 4'b1001;
      setd(0, 32'h60);
      #1 chk("s6_idle2", 0, 0, 0, 4'b0000, 0);
      cyc();
      #1 chk("s6_req0", 1, 0, 32'h60, 4'b0001, 1);
      cyc();
      vld = '0;
      lst = '0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
